sram_wrr_arbiter: RTL and testbench
===================================

# sram_wrr_arbiter

Parametrised successor to the two-requester SRAM arbiter. Arbitrates NUM_PORTS read/write requesters onto one pipelined ZBT SRAM using weighted round-robin with per-port programmable weights. Issues one access per cycle with no idle cycles while any request is pending, and returns tagged read data. It sits between the datapath/register-access requesters and the SRAM pins.

## Interface
Parameters:
- NUM_PORTS, 4: requester count, 1..16.
- SRAM_ADDR_WIDTH, 19: SRAM word address width.
- SRAM_DATA_WIDTH, 36: data width; multiple of 9.
- WEIGHT_WIDTH, 4: per-port weight width.
- WR_LATENCY, 2: cycles from sram_addr to sram_wr_data.
- RD_LATENCY, 2: cycles from sram_addr to valid sram_rd_data.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- req  in  NUM_PORTS  per-port access request.
- rd_wr_L  in  NUM_PORTS  1 = read, 0 = write.
- addr  in  NUM_PORTS*SRAM_ADDR_WIDTH  flattened per-port address; port p at [p*AW +: AW].
- wr_data  in  NUM_PORTS*SRAM_DATA_WIDTH  flattened per-port write data.
- weight  in  NUM_PORTS*WEIGHT_WIDTH  flattened per-port weight; 0 is treated as 1.
- ack  out  NUM_PORTS  one-hot grant; request consumed.
- rd_data  out  SRAM_DATA_WIDTH  shared read-return bus.
- rd_vld  out  NUM_PORTS  one-hot; rd_data belongs to that port.
- sram_addr  out  SRAM_ADDR_WIDTH  SRAM address.
- sram_we  out  1  1 = write cycle.
- sram_bw  out  SRAM_DATA_WIDTH/9  byte enables, 1 = enabled.
- sram_wr_data  out  SRAM_DATA_WIDTH  write data.
- sram_rd_data  in  SRAM_DATA_WIDTH  read data from the pins.
- sram_tri_en  out  1  1 = FPGA drives the data bus.

## Operation
- State: current port pointer cur and credit counter credit (WEIGHT_WIDTH bits).
- Each cycle: if req[cur] and credit > 0, grant cur and decrement credit. Otherwise grant the next requesting port searching cyclically from cur+1, set cur to it, and set credit = eff_weight - 1.
- eff_weight = max(weight, 1).
- At most one ack per cycle. No requests: no grant, state unchanged.
- A single active requester is granted every cycle; it reloads from itself.
- Weight changes take effect at that port's next reload; a running burst is not altered.
- Requester holds req, rd_wr_L, addr and wr_data stable until ack. After ack it may present a new access in the next cycle.
- Write: sram_bw is all ones. The captured wr_data travels through a WR_LATENCY-deep pipeline.
- Read: the port index travels through a tag pipeline. rd_data is sram_rd_data registered once.
- Reset state: cur = NUM_PORTS-1 and credit = 0, so the first grant goes to the lowest-index requester.
- Reset mid-operation: all pipelines flush. In-flight writes are abandoned with tri_en deasserted. In-flight reads produce no rd_vld.

## Timing
- Grant cycle T: ack[p] = 1 combinationally in T, from registered state and req.
- T+1: sram_addr, sram_we and sram_bw are valid for one cycle. When idle, sram_we = 0 and sram_bw = 0.
- Write: sram_wr_data and sram_tri_en = 1 at T+1+WR_LATENCY, for one cycle.
- Read: rd_vld[p] = 1 with rd_data at T+2+RD_LATENCY, for one cycle.
- Back-to-back mixed reads and writes are allowed every cycle; no turnaround bubble is inserted (ZBT).
- Reset values: ack = 0, rd_vld = 0, rd_data = 0, sram_addr = 0, sram_we = 0, sram_bw = 0, sram_wr_data = 0, sram_tri_en = 0.

## Structure
- Shared include file (sram_arb_defines.v) holds:
  - a log2 function for the pointer width;
  - default WR_LATENCY and RD_LATENCY constants;
  - the byte-lane constant 9.
- Sub-module wrr_grant holds cur, credit, the cyclic priority search and the one-hot grant. Parameters: NUM_PORTS and WEIGHT_WIDTH.
- The top level contains the issue register, the write-data pipeline, the read-tag pipeline and the return register.

## Test plan
- Weights {3,1,2,1} with all four ports reading continuously. Required grant pattern repeats 0,0,0,1,2,2,3 with no idle cycle.
- Port 2 alone writes 0x5A5A5A5A5 to address 0x100 at T. Required: sram_addr = 0x100 with sram_we = 1 at T+1; sram_wr_data = 0x5A5A5A5A5 with tri_en = 1 at T+3.
- Port 1 reads address 0x100 at T; the SRAM model returns the value at T+3. Required: rd_vld = 4'b0010 with rd_data = 0x5A5A5A5A5 at T+4.
- Weight 0 on port 0 while ports 0 and 1 request continuously. Required: strict alternation 0,1,0,1.
- Change weight[0] from 3 to 1 during port 0's burst. Required: the burst completes 3 grants, and the next burst is 1 grant.
- Assert reset with two reads in flight. Required: no rd_vld, all outputs at reset values, and the first grant after release goes to the lowest requesting index.

Source files
------------

// File: rtl/sram_wrr_arbiter_pkg.sv
// Shared constants and helpers for the weighted round-robin SRAM arbiter.
package sram_wrr_arbiter_pkg;

  localparam int unsigned BYTE_LANE_W    = 9;
  localparam int unsigned DEF_WR_LATENCY = 2;
  localparam int unsigned DEF_RD_LATENCY = 2;

  // Pointer width for n requesters; never narrower than one bit.
  function automatic int unsigned log2_ceil(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sram_wrr_arbiter_wrr_grant.sv
// Weighted round-robin grant: current pointer, burst credit and cyclic search.
module wrr_grant
  import sram_wrr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned WEIGHT_WIDTH = 4,
  localparam int unsigned PTR_W       = log2_ceil(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight_i,
  output logic [NUM_PORTS-1:0]              gnt_c,
  output logic [PTR_W-1:0]                  gnt_idx_c,
  output logic                              gnt_vld_c
);

  logic [PTR_W-1:0]        cur_q, cur_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [WEIGHT_WIDTH-1:0] w_sel;
  logic                    found;
  logic [PTR_W-1:0]        sel;
  int unsigned             idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_q    <= PTR_W'(NUM_PORTS - 1);
      credit_q <= '0;
    end else begin
      cur_q    <= cur_d;
      credit_q <= credit_d;
    end
  end

  // Stay on cur while credit remains, else reload from the next requester after cur.
  always_comb begin
    cur_d     = cur_q;
    credit_d  = credit_q;
    gnt_vld_c = 1'b0;
    gnt_idx_c = cur_q;
    gnt_c     = '0;
    found     = 1'b0;
    sel       = cur_q;
    idx       = 0;
    w_sel     = '0;

    if (req_i[cur_q] && (credit_q != '0)) begin
      gnt_vld_c = 1'b1;
      credit_d  = credit_q - WEIGHT_WIDTH'(1);
    end else begin
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
        idx = (32'(cur_q) + k) % NUM_PORTS;
        if (!found && req_i[PTR_W'(idx)]) begin
          found = 1'b1;
          sel   = PTR_W'(idx);
        end
      end
      if (found) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = sel;
        cur_d     = sel;
        w_sel     = weight_i[32'(sel)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        credit_d  = (w_sel == '0) ? '0 : w_sel - WEIGHT_WIDTH'(1);
      end
    end

    if (!reset) begin
      gnt_vld_c = 1'b0;
      cur_d     = cur_q;
      credit_d  = credit_q;
    end
    gnt_c[gnt_idx_c] = gnt_vld_c;
  end

endmodule

// File: rtl/sram_wrr_arbiter.sv
// Multi-port ZBT SRAM arbiter: WRR grant, issue register, write-data and read-tag pipelines.
module sram_wrr_arbiter
  import sram_wrr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned SRAM_ADDR_WIDTH = 19,
  parameter int unsigned SRAM_DATA_WIDTH = 36,
  parameter int unsigned WEIGHT_WIDTH    = 4,
  parameter int unsigned WR_LATENCY      = DEF_WR_LATENCY,
  parameter int unsigned RD_LATENCY      = DEF_RD_LATENCY
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 req,
  input  logic [NUM_PORTS-1:0]                 rd_wr_L,
  input  logic [NUM_PORTS*SRAM_ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*SRAM_DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0]    weight,
  output logic [NUM_PORTS-1:0]                 ack,
  output logic [SRAM_DATA_WIDTH-1:0]           rd_data,
  output logic [NUM_PORTS-1:0]                 rd_vld,
  output logic [SRAM_ADDR_WIDTH-1:0]           sram_addr,
  output logic                                 sram_we,
  output logic [SRAM_DATA_WIDTH/9-1:0]         sram_bw,
  output logic [SRAM_DATA_WIDTH-1:0]           sram_wr_data,
  input  logic [SRAM_DATA_WIDTH-1:0]           sram_rd_data,
  output logic                                 sram_tri_en
);

  localparam int unsigned PTR_W = log2_ceil(NUM_PORTS);
  localparam int unsigned BW_W  = SRAM_DATA_WIDTH / BYTE_LANE_W;
  localparam int unsigned AW    = SRAM_ADDR_WIDTH;
  localparam int unsigned DW    = SRAM_DATA_WIDTH;

  logic [NUM_PORTS-1:0] gnt_c;
  logic [PTR_W-1:0]     gnt_idx_c;
  logic                 gnt_vld_c;

  wrr_grant #(
    .NUM_PORTS    (NUM_PORTS),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_grant (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .weight_i  (weight),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_vld_c (gnt_vld_c)
  );

  // Issue register: drives the SRAM control pins the cycle after the grant.
  logic [AW-1:0]    sram_addr_q, sram_addr_d;
  logic             sram_we_q, sram_we_d;
  logic [BW_W-1:0]  sram_bw_q, sram_bw_d;
  logic [DW-1:0]    iss_wdata_q, iss_wdata_d;
  logic             iss_rd_q, iss_rd_d;
  logic [PTR_W-1:0] iss_tag_q, iss_tag_d;

  always_comb begin
    sram_addr_d = sram_addr_q;
    sram_we_d   = 1'b0;
    sram_bw_d   = '0;
    iss_wdata_d = '0;
    iss_rd_d    = 1'b0;
    iss_tag_d   = gnt_idx_c;
    if (gnt_vld_c) begin
      sram_addr_d = addr[32'(gnt_idx_c)*AW +: AW];
      sram_we_d   = ~rd_wr_L[gnt_idx_c];
      sram_bw_d   = '1;
      iss_wdata_d = wr_data[32'(gnt_idx_c)*DW +: DW];
      iss_rd_d    = rd_wr_L[gnt_idx_c];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sram_addr_q <= '0;
      sram_we_q   <= 1'b0;
      sram_bw_q   <= '0;
      iss_wdata_q <= '0;
      iss_rd_q    <= 1'b0;
      iss_tag_q   <= '0;
    end else begin
      sram_addr_q <= sram_addr_d;
      sram_we_q   <= sram_we_d;
      sram_bw_q   <= sram_bw_d;
      iss_wdata_q <= iss_wdata_d;
      iss_rd_q    <= iss_rd_d;
      iss_tag_q   <= iss_tag_d;
    end
  end

  // Write-data pipeline; data is zeroed outside the drive cycle.
  logic [WR_LATENCY-1:0]         wr_vld_q, wr_vld_d;
  logic [WR_LATENCY-1:0][DW-1:0] wr_data_q, wr_data_d;

  always_comb begin
    wr_vld_d[0]  = sram_we_q;
    wr_data_d[0] = sram_we_q ? iss_wdata_q : '0;
    for (int i = 1; i < int'(WR_LATENCY); i++) begin
      wr_vld_d[i]  = wr_vld_q[i-1];
      wr_data_d[i] = wr_data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_vld_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_vld_q  <= wr_vld_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Read-tag pipeline aligned with the SRAM read latency.
  logic [RD_LATENCY-1:0]            rd_pvld_q, rd_pvld_d;
  logic [RD_LATENCY-1:0][PTR_W-1:0] rd_ptag_q, rd_ptag_d;

  always_comb begin
    rd_pvld_d[0] = iss_rd_q;
    rd_ptag_d[0] = iss_tag_q;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      rd_pvld_d[i] = rd_pvld_q[i-1];
      rd_ptag_d[i] = rd_ptag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_pvld_q <= '0;
      rd_ptag_q <= '0;
    end else begin
      rd_pvld_q <= rd_pvld_d;
      rd_ptag_q <= rd_ptag_d;
    end
  end

  // Return register: captures pin data only when a tagged read lands.
  logic [NUM_PORTS-1:0] rd_vld_q, rd_vld_d;
  logic [DW-1:0]        rd_data_q, rd_data_d;

  always_comb begin
    rd_vld_d  = '0;
    rd_data_d = rd_data_q;
    if (rd_pvld_q[RD_LATENCY-1]) begin
      rd_vld_d[rd_ptag_q[RD_LATENCY-1]] = 1'b1;
      rd_data_d                         = sram_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_vld_q  <= '0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign ack          = gnt_c;
  assign sram_addr    = sram_addr_q;
  assign sram_we      = sram_we_q;
  assign sram_bw      = sram_bw_q;
  assign sram_wr_data = wr_data_q[WR_LATENCY-1];
  assign sram_tri_en  = wr_vld_q[WR_LATENCY-1];
  assign rd_vld       = rd_vld_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_sram_wrr_arbiter.sv
// Directed bench for sram_wrr_arbiter with a small ZBT SRAM model.
module tb_sram_wrr_arbiter;

  localparam int NP = 4;
  localparam int AW = 19;
  localparam int DW = 36;
  localparam int WW = 4;

  logic              clk;
  logic              reset;
  logic [NP-1:0]     req;
  logic [NP-1:0]     rd_wr_L;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wr_data;
  logic [NP*WW-1:0]  weight;
  logic [NP-1:0]     ack;
  logic [DW-1:0]     rd_data;
  logic [NP-1:0]     rd_vld;
  logic [AW-1:0]     sram_addr;
  logic              sram_we;
  logic [DW/9-1:0]   sram_bw;
  logic [DW-1:0]     sram_wr_data;
  logic [DW-1:0]     sram_rd_data;
  logic              sram_tri_en;

  int n_tot;
  int n_bad;

  sram_wrr_arbiter #(
    .NUM_PORTS       (NP),
    .SRAM_ADDR_WIDTH (AW),
    .SRAM_DATA_WIDTH (DW),
    .WEIGHT_WIDTH    (WW),
    .WR_LATENCY      (2),
    .RD_LATENCY      (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .rd_wr_L      (rd_wr_L),
    .addr         (addr),
    .wr_data      (wr_data),
    .weight       (weight),
    .ack          (ack),
    .rd_data      (rd_data),
    .rd_vld       (rd_vld),
    .sram_addr    (sram_addr),
    .sram_we      (sram_we),
    .sram_bw      (sram_bw),
    .sram_wr_data (sram_wr_data),
    .sram_rd_data (sram_rd_data),
    .sram_tri_en  (sram_tri_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: address pipelined two cycles, write data and read data land together.
  logic [DW-1:0] mem [1024];
  logic [AW-1:0] a_h1, a_h2;

  always @(posedge clk) begin
    a_h1 <= sram_addr;
    a_h2 <= a_h1;
    if (sram_tri_en) mem[a_h2[9:0]] <= sram_wr_data;
  end
  assign sram_rd_data = mem[a_h2[9:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] pat1 [7];
  logic [3:0] pat5 [6];
  logic [DW-1:0] wval;

  initial begin
    n_tot   = 0;
    n_bad   = 0;
    a_h1    = '0;
    a_h2    = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    pat1    = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h4, 4'h8};
    pat5    = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h1, 4'h2};
    wval    = 36'h5A5A5A5A5;
    reset   = 1'b0;
    req     = '0;
    rd_wr_L = '1;
    addr    = '0;
    wr_data = '0;
    weight  = {4'd1, 4'd2, 4'd1, 4'd3};

    // Reset values
    step(); step();
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_bw", sram_bw, 0);
    chk("rst_wdata", sram_wr_data, 0);
    chk("rst_tri", sram_tri_en, 0);

    // Weights {3,1,2,1}, all ports reading continuously
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 0) begin
        reset = 1'b1;
        req   = 4'hF;
      end
      #1;
      chk($sformatf("wrr_ack_%0d", i), ack, pat1[i % 7]);
      if (i >= 4) chk($sformatf("wrr_rdvld_%0d", i), rd_vld, pat1[(i - 4) % 7]);
    end
    step();
    req = '0;
    #1;
    chk("idle_ack", ack, 0);
    step(); #1;
    chk("idle_we", sram_we, 0);
    chk("idle_bw", sram_bw, 0);
    repeat (4) step();

    // Port 2 writes 0x5A5A5A5A5 to 0x100
    step();
    req             = 4'b0100;
    rd_wr_L         = 4'b1011;
    addr[2*AW +: AW] = 19'h100;
    wr_data[2*DW +: DW] = wval;
    #1;
    chk("wr_ack", ack, 4'b0100);
    step();
    req = '0;
    #1;
    chk("wr_addr", sram_addr, 19'h100);
    chk("wr_we", sram_we, 1);
    chk("wr_bw", sram_bw, 4'hF);
    step(); #1;
    chk("wr_tri_early", sram_tri_en, 0);
    step(); #1;
    chk("wr_data", sram_wr_data, wval);
    chk("wr_tri", sram_tri_en, 1);
    step(); #1;
    chk("wr_tri_after", sram_tri_en, 0);

    // Port 1 reads 0x100 back
    step();
    req              = 4'b0010;
    rd_wr_L          = 4'hF;
    addr[1*AW +: AW] = 19'h100;
    #1;
    chk("rd_ack", ack, 4'b0010);
    step();
    req = '0;
    #1;
    chk("rd_addr", sram_addr, 19'h100);
    chk("rd_we", sram_we, 0);
    step();
    step(); #1;
    chk("rd_vld_early", rd_vld, 0);
    step(); #1;
    chk("rd_vld", rd_vld, 4'b0010);
    chk("rd_data", rd_data, wval);
    step(); #1;
    chk("rd_vld_after", rd_vld, 0);

    // Weight 0 on port 0: strict alternation with port 1
    weight[3:0] = 4'd0;
    weight[7:4] = 4'd1;
    for (int i = 0; i < 6; i++) begin
      step();
      req = 4'b0011;
      #1;
      chk($sformatf("w0_ack_%0d", i), ack, (i % 2 == 0) ? 4'b0001 : 4'b0010);
    end

    // Weight 3 -> 1 mid-burst: burst stays 3, next burst is 1
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) weight[3:0] = 4'd3;
      if (i == 2) weight[3:0] = 4'd1;
      #1;
      chk($sformatf("wchg_ack_%0d", i), ack, pat5[i]);
    end

    // Reset with two reads in flight
    step();
    req = 4'b0001;
    #1;
    chk("fl_ack0", ack, 4'b0001);
    step();
    req = 4'b0010;
    #1;
    chk("fl_ack1", ack, 4'b0010);
    step();
    reset = 1'b0;
    req   = 4'b0110;
    #1;
    chk("fl_rst_ack", ack, 0);
    step(); #1;
    chk("fl_ack_in_rst", ack, 0);
    chk("fl_rd_vld", rd_vld, 0);
    chk("fl_rd_data", rd_data, 0);
    chk("fl_addr", sram_addr, 0);
    chk("fl_we", sram_we, 0);
    chk("fl_bw", sram_bw, 0);
    chk("fl_wdata", sram_wr_data, 0);
    chk("fl_tri", sram_tri_en, 0);
    step();
    reset = 1'b1;
    #1;
    chk("fl_first_gnt", ack, 4'b0010);
    chk("fl_no_vld0", rd_vld, 0);
    step();
    req = '0;
    #1;
    chk("fl_no_vld1", rd_vld, 0);
    step(); #1;
    chk("fl_no_vld2", rd_vld, 0);
    step(); #1;
    chk("fl_no_vld3", rd_vld, 0);
    step(); #1;
    chk("fl_new_vld", rd_vld, 4'b0010);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
